// File: rtl/lake_config_loader.sv
// Assembles lakespec's flat config_memory from an addr/data ready-valid stream,
// tracks which slots have been written, flags protocol errors and offers registered readback.
module lake_config_loader #(
  parameter int  CONFIG_MEMORY_SIZE = 512,
  parameter int  WORD_WIDTH         = 32,
  localparam int NUM_WORDS          = (CONFIG_MEMORY_SIZE + WORD_WIDTH - 1) / WORD_WIDTH,
  localparam int ADDR_WIDTH         = ($clog2(NUM_WORDS) + 1 > 1) ? $clog2(NUM_WORDS) + 1 : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_clear,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [ADDR_WIDTH-1:0]         cfg_addr,
  input  logic [WORD_WIDTH-1:0]         cfg_data,
  input  logic                          cfg_last,
  input  logic                          rd_en,
  input  logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic                          rd_valid,
  output logic [WORD_WIDTH-1:0]         rd_data,
  output logic [CONFIG_MEMORY_SIZE-1:0] config_memory,
  output logic                          config_done,
  output logic                          cfg_err
);

  // state | meaning
  // IDLE  | nothing accepted since reset/clear
  // LOAD  | at least one beat accepted, cfg_last not yet seen
  // DONE  | cfg_last accepted; memory frozen until clear/reset
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int PAD_SIZE = NUM_WORDS * WORD_WIDTH;

  state_t                  state_q, state_d;
  logic                    accept;
  logic                    addr_oor;
  logic [NUM_WORDS-1:0]    beat_sel;
  logic [NUM_WORDS-1:0]    mask_q, mask_d;
  logic [PAD_SIZE-1:0]     mem_q;
  logic [WORD_WIDTH-1:0]   rd_word;
  logic                    done_q;
  logic                    err_q;

  // Bits of a slot that land inside config_memory; the rest are never stored,
  // so the padding above CONFIG_MEMORY_SIZE stays zero and reads back as zero.
  function automatic logic [WORD_WIDTH-1:0] slot_keep(input int slot);
    logic [WORD_WIDTH-1:0] keep;
    keep = '0;
    for (int b = 0; b < WORD_WIDTH; b++)
      keep[b] = (slot * WORD_WIDTH + b) < CONFIG_MEMORY_SIZE;
    return keep;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cfg_clear)   state_d = ST_IDLE;
    else if (accept) state_d = cfg_last ? ST_DONE : ST_LOAD;
  end

  always_comb begin
    cfg_ready = (state_q != ST_DONE);
    accept    = cfg_valid && (state_q != ST_DONE);
  end

  always_comb begin
    beat_sel = '0;
    for (int s = 0; s < NUM_WORDS; s++)
      beat_sel[s] = accept && (cfg_addr == ADDR_WIDTH'(s));
    addr_oor = (cfg_addr >= ADDR_WIDTH'(NUM_WORDS));
    mask_d   = mask_q | beat_sel;
  end

  // Clear wins over a same-cycle accept, so the beat is dropped entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      mask_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (cfg_clear) begin
      mem_q  <= '0;
      mask_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      for (int s = 0; s < NUM_WORDS; s++)
        if (beat_sel[s]) mem_q[s*WORD_WIDTH +: WORD_WIDTH] <= cfg_data & slot_keep(s);
      mask_q <= mask_d;
      if (accept && cfg_last) done_q <= 1'b1;
      if (accept && (addr_oor || (cfg_last && !(&mask_d)))) err_q <= 1'b1;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int s = 0; s < NUM_WORDS; s++)
      if (rd_addr == ADDR_WIDTH'(s)) rd_word = mem_q[s*WORD_WIDTH +: WORD_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_word;
    end
  end

  assign config_memory = mem_q[CONFIG_MEMORY_SIZE-1:0];
  assign config_done   = done_q;
  assign cfg_err       = err_q;

endmodule

// File: tb/tb_lake_config_loader.sv
// Directed bench for lake_config_loader: default 512-bit instance plus a
// 100-bit instance exercising last-slot truncation; readback checked via a scoreboard queue.
module tb_lake_config_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic         a_clear, a_valid, a_ready, a_last, a_rd_en, a_rd_valid, a_done, a_err;
  logic [4:0]   a_addr, a_rd_addr;
  logic [31:0]  a_data, a_rd_data;
  logic [511:0] a_mem;

  logic         b_clear, b_valid, b_ready, b_last, b_rd_en, b_rd_valid, b_done, b_err;
  logic [2:0]   b_addr, b_rd_addr;
  logic [31:0]  b_data, b_rd_data;
  logic [99:0]  b_mem;

  lake_config_loader u_dut_a (
    .clk(clk), .rst_n(rst_n), .cfg_clear(a_clear), .cfg_valid(a_valid), .cfg_ready(a_ready),
    .cfg_addr(a_addr), .cfg_data(a_data), .cfg_last(a_last), .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .rd_valid(a_rd_valid), .rd_data(a_rd_data), .config_memory(a_mem), .config_done(a_done),
    .cfg_err(a_err)
  );

  lake_config_loader #(.CONFIG_MEMORY_SIZE(100), .WORD_WIDTH(32)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_clear(b_clear), .cfg_valid(b_valid), .cfg_ready(b_ready),
    .cfg_addr(b_addr), .cfg_data(b_data), .cfg_last(b_last), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data), .config_memory(b_mem), .config_done(b_done),
    .cfg_err(b_err)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] model [16];
  logic [31:0] exp_a [$];
  logic [31:0] exp_b [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [511:0] model_vec();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = model[i];
    return v;
  endfunction

  task automatic model_zero();
    for (int i = 0; i < 16; i++) model[i] = '0;
  endtask

  task automatic wr_a(input logic [4:0] addr, input logic [31:0] data, input logic last);
    a_valid = 1'b1; a_addr = addr; a_data = data; a_last = last;
    step();
    a_valid = 1'b0; a_last = 1'b0;
    if (addr < 16) model[addr[3:0]] = data;
  endtask

  task automatic rd_check_a(input string tag);
    logic [31:0] e;
    chk({tag, "_valid"}, a_rd_valid, 1'b1);
    e = (exp_a.size() > 0) ? exp_a.pop_front() : 32'hx;
    chk(tag, a_rd_data, e);
  endtask

  task automatic rd_a(input string tag, input logic [4:0] addr, input logic [31:0] expv);
    a_rd_en = 1'b1; a_rd_addr = addr;
    exp_a.push_back(expv);
    step();
    a_rd_en = 1'b0;
    rd_check_a(tag);
  endtask

  task automatic clear_a();
    a_clear = 1'b1;
    step();
    a_clear = 1'b0;
    model_zero();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] e;
    rst_n = 1'b1;
    a_clear = 0; a_valid = 0; a_last = 0; a_rd_en = 0; a_addr = '0; a_rd_addr = '0; a_data = '0;
    b_clear = 0; b_valid = 0; b_last = 0; b_rd_en = 0; b_addr = '0; b_rd_addr = '0; b_data = '0;
    model_zero();
    step(); step();

    // reset asserted mid-cycle must clear outputs without waiting for a clock
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mem",      a_mem, '0);
    chk("rst_done",     a_done, 1'b0);
    chk("rst_err",      a_err, 1'b0);
    chk("rst_rd_valid", a_rd_valid, 1'b0);
    chk("rst_mem_b",    b_mem, '0);
    #2 rst_n = 1'b1;
    step();
    chk("rst_ready", a_ready, 1'b1);

    for (int i = 0; i < 16; i++) wr_a(5'(i), 32'hA5A50000 + 32'(i), i == 15);
    chk("load_done",  a_done, 1'b1);
    chk("load_ready", a_ready, 1'b0);
    chk("load_err",   a_err, 1'b0);
    chk("load_lo",    a_mem[31:0], 32'hA5A50000);
    chk("load_hi",    a_mem[511:480], 32'hA5A5000F);
    chk("load_all",   a_mem, model_vec());

    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h1234; a_last = 1'b1;
    step(); step(); step();
    a_valid = 1'b0; a_last = 1'b0;
    chk("done_frozen", a_mem, model_vec());
    chk("done_hold",   a_done, 1'b1);
    chk("done_err",    a_err, 1'b0);
    rd_a("rd_done_15", 5'd15, 32'hA5A5000F);
    rd_a("rd_oor",     5'd20, 32'h0);

    clear_a();
    chk("clr_mem",   a_mem, '0);
    chk("clr_done",  a_done, 1'b0);
    chk("clr_ready", a_ready, 1'b1);

    wr_a(5'd0, 32'h11, 1'b0);
    wr_a(5'd16, 32'hDEADBEEF, 1'b0);
    chk("oor_mem",   a_mem, model_vec());
    chk("oor_err",   a_err, 1'b1);
    chk("oor_ready", a_ready, 1'b1);
    clear_a();
    chk("clr_err", a_err, 1'b0);

    for (int i = 0; i < 16; i++)
      if (i != 7) wr_a(5'(i), 32'h100 + 32'(i), i == 15);
    chk("gap_done", a_done, 1'b1);
    chk("gap_err",  a_err, 1'b1);
    chk("gap_mem",  a_mem, model_vec());
    clear_a();

    a_valid = 1'b1; a_addr = 5'd2; a_data = 32'h55; a_last = 1'b1; a_clear = 1'b1;
    step();
    a_valid = 1'b0; a_last = 1'b0; a_clear = 1'b0;
    chk("clrbeat_mem",   a_mem, '0);
    chk("clrbeat_done",  a_done, 1'b0);
    chk("clrbeat_ready", a_ready, 1'b1);

    wr_a(5'd3, 32'h0BADF00D, 1'b0);
    rd_a("rd_slot3", 5'd3, 32'h0BADF00D);
    // a write in the same cycle as the read must not be forwarded
    a_valid = 1'b1; a_addr = 5'd4; a_data = 32'hCAFEF00D; a_last = 1'b0;
    a_rd_en = 1'b1; a_rd_addr = 5'd4;
    exp_a.push_back(32'h0);
    step();
    a_valid = 1'b0; a_rd_en = 1'b0;
    model[4] = 32'hCAFEF00D;
    rd_check_a("rd_nofwd");
    rd_a("rd_slot4", 5'd4, 32'hCAFEF00D);
    wr_a(5'd3, 32'h12345678, 1'b0);
    rd_a("rd_rewrite", 5'd3, 32'h12345678);

    clear_a();
    for (int i = 0; i < 5; i++) wr_a(5'(i), 32'h5000 + 32'(i), 1'b0);
    #3 rst_n = 1'b0;
    #1;
    model_zero();
    chk("midrst_mem",  a_mem, '0);
    chk("midrst_done", a_done, 1'b0);
    chk("midrst_err",  a_err, 1'b0);
    #2 rst_n = 1'b1;
    step();
    chk("midrst_ready", a_ready, 1'b1);
    for (int i = 0; i < 16; i++) wr_a(5'(i), 32'hFFFF0000 | 32'(i), i == 15);
    chk("reload_done", a_done, 1'b1);
    chk("reload_err",  a_err, 1'b0);
    chk("reload_mem",  a_mem, model_vec());

    // 100-bit instance: slot 3 keeps only bits [99:96]
    b_valid = 1'b1; b_addr = 3'd3; b_data = 32'hFFFFFFFF; b_last = 1'b0;
    step();
    b_valid = 1'b0;
    chk("trunc_top", b_mem[99:96], 4'hF);
    chk("trunc_low", b_mem[95:0], '0);
    b_rd_en = 1'b1; b_rd_addr = 3'd3;
    exp_b.push_back(32'h0000000F);
    step();
    b_rd_en = 1'b0;
    chk("trunc_rd_valid", b_rd_valid, 1'b1);
    e = (exp_b.size() > 0) ? exp_b.pop_front() : 32'hx;
    chk("trunc_rd", b_rd_data, e);
    b_valid = 1'b1; b_addr = 3'd4; b_data = 32'h1; b_last = 1'b1;
    step();
    b_valid = 1'b0; b_last = 1'b0;
    chk("b_oor_done", b_done, 1'b1);
    chk("b_oor_err",  b_err, 1'b1);
    chk("b_oor_mem",  b_mem, {4'hF, 96'h0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
